mem_bus_if: RTL and testbench

MEM_BUS_IF -- requirements
Module: mem_bus_if

---
 rtl/mem_bus_if_pkg.sv | 17 +
 rtl/mem_bus_if_if.sv | 24 ++
 rtl/bus_wait_ctr.sv | 26 ++
 rtl/mem_bus_if.sv | 150 +++++++++++++++
 tb/tb_mem_bus_if.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_if_pkg.sv
// Shared types and defaults for the external memory bus controller.
package mem_bus_if_pkg;

   typedef logic [15:0] word_t;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ADDR   = 3'd1,
      ACCESS = 3'd2,
      WAIT   = 3'd3,
      DONE   = 3'd4
   } bus_state_e;

   localparam int WAIT_MIN_DEFAULT = 1;
   localparam int TIMEOUT_DEFAULT  = 15;

endpackage

// File: rtl/mem_bus_if_if.sv
// External memory-side signals: the controller is the master, the memory the slave.
interface mem_bus_if_if;
   import mem_bus_if_pkg::*;

   word_t addr;
   word_t wr_data;
   logic  wr_data_oe;
   logic  n_me;
   logic  n_oe;
   logic  n_we;
   word_t ext_data;
   logic  n_wait;

   modport master (
      output addr, wr_data, wr_data_oe, n_me, n_oe, n_we,
      input  ext_data, n_wait
   );

   modport slave (
      input  addr, wr_data, wr_data_oe, n_me, n_oe, n_we,
      output ext_data, n_wait
   );

endinterface

// File: rtl/bus_wait_ctr.sv
// Saturating 8-bit cycle counter; tc flags the cycle in which the limit-th cycle is running.
module bus_wait_ctr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       enable,
   input  logic [7:0] limit,
   output logic       tc
);

   logic [7:0] count;

   // Saturates at 8'hFF so a long wait can never wrap back to a small count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 8'h00;
      end else if (clear) begin
         count <= 8'h00;
      end else if (enable && (count != 8'hFF)) begin
         count <= count + 8'h01;
      end
   end

   assign tc = (({1'b0, count} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/mem_bus_if.sv
// Memory bus controller: sequences one external read or write per request, with wait and timeout.
module mem_bus_if
   import mem_bus_if_pkg::*;
#(
   parameter int WAIT_MIN = WAIT_MIN_DEFAULT,
   parameter int TIMEOUT  = TIMEOUT_DEFAULT
) (
   input  logic           clk,
   input  logic           rst_n,
   input  word_t          sys_bus,
   input  logic           read_req,
   input  logic           write_req,
   output word_t          data_in,
   output logic           stall,
   output logic           done,
   output logic           bus_err,
   mem_bus_if_if.master   mem
);

   localparam logic [2:0] ST_IDLE   = IDLE;
   localparam logic [2:0] ST_ADDR   = ADDR;
   localparam logic [2:0] ST_ACCESS = ACCESS;
   localparam logic [2:0] ST_WAIT   = WAIT;
   localparam logic [2:0] ST_DONE   = DONE;

   logic [2:0] state;
   logic [2:0] state_nx;
   logic       is_write;
   logic       req_ok;
   logic       req_both;
   logic       timed_out;
   logic       leaving_access;
   logic       ctr_clear;
   logic       ctr_en;
   logic       ctr_tc;
   logic [7:0] ctr_limit;

   word_t      addr_q;
   word_t      wr_data_q;
   word_t      data_in_q;
   logic       wr_data_oe_q;
   logic       n_me_q;
   logic       n_oe_q;
   logic       n_we_q;
   logic       bus_err_q;

   assign req_both  = read_req & write_req;
   assign req_ok    = read_req ^ write_req;
   assign ctr_en    = (state == ST_ACCESS) || (state == ST_WAIT);
   assign ctr_limit = (state == ST_ACCESS) ? 8'(WAIT_MIN) : 8'(TIMEOUT);

   bus_wait_ctr u_wait_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (ctr_clear),
      .enable (ctr_en),
      .limit  (ctr_limit),
      .tc     (ctr_tc)
   );

   // The counter is restarted entering ACCESS (minimum hold) and again entering WAIT (timeout).
   always_comb begin
      state_nx  = state;
      ctr_clear = 1'b0;
      timed_out = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req_ok) state_nx = ST_ADDR;
         end
         ST_ADDR: begin
            state_nx  = ST_ACCESS;
            ctr_clear = 1'b1;
         end
         ST_ACCESS: begin
            if (ctr_tc) begin
               if (mem.n_wait) begin
                  state_nx = ST_DONE;
               end else begin
                  state_nx  = ST_WAIT;
                  ctr_clear = 1'b1;
               end
            end
         end
         ST_WAIT: begin
            if (mem.n_wait) begin
               state_nx = ST_DONE;
            end else if (ctr_tc) begin
               state_nx  = ST_DONE;
               timed_out = 1'b1;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   assign leaving_access = ((state == ST_ACCESS) || (state == ST_WAIT)) && (state_nx == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         is_write     <= 1'b0;
         addr_q       <= 16'h0000;
         wr_data_q    <= 16'h0000;
         data_in_q    <= 16'h0000;
         wr_data_oe_q <= 1'b0;
         n_me_q       <= 1'b1;
         n_oe_q       <= 1'b1;
         n_we_q       <= 1'b1;
         bus_err_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         bus_err_q <= ((state == ST_IDLE) && req_both) || timed_out;
         if ((state == ST_IDLE) && req_ok) begin
            addr_q   <= sys_bus;
            is_write <= write_req;
         end
         // Strobes go active on the ADDR->ACCESS edge so they are registered for the whole access.
         if (state == ST_ADDR) begin
            n_me_q <= 1'b0;
            n_oe_q <= is_write;
            n_we_q <= ~is_write;
            if (is_write) begin
               wr_data_q    <= sys_bus;
               wr_data_oe_q <= 1'b1;
            end
         end
         if (leaving_access) begin
            n_me_q       <= 1'b1;
            n_oe_q       <= 1'b1;
            n_we_q       <= 1'b1;
            wr_data_oe_q <= 1'b0;
            if (!is_write && !timed_out) data_in_q <= mem.ext_data;
         end
      end
   end

   assign mem.addr       = addr_q;
   assign mem.wr_data    = wr_data_q;
   assign mem.wr_data_oe = wr_data_oe_q;
   assign mem.n_me       = n_me_q;
   assign mem.n_oe       = n_oe_q;
   assign mem.n_we       = n_we_q;

   assign data_in = data_in_q;
   assign bus_err = bus_err_q;
   assign done    = (state == ST_DONE);
   assign stall   = (state == ST_ADDR) || (state == ST_ACCESS) || (state == ST_WAIT);

endmodule

// File: tb/tb_mem_bus_if.sv
// Randomized scoreboard bench for mem_bus_if against a transaction-level timing model.
module tb_mem_bus_if;
   import mem_bus_if_pkg::word_t;

   localparam int WM = 1;
   localparam int TO = 15;

   logic  clk;
   logic  rst_n;
   logic  read_req;
   logic  write_req;
   logic  stall;
   logic  done;
   logic  bus_err;
   word_t sys_bus;
   word_t data_in;

   int cyc   = 0;
   int n_vec = 0;
   int n_mis = 0;

   mem_bus_if_if bus ();

   mem_bus_if #(.WAIT_MIN(WM), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sys_bus   (sys_bus),
      .read_req  (read_req),
      .write_req (write_req),
      .data_in   (data_in),
      .stall     (stall),
      .done      (done),
      .bus_err   (bus_err),
      .mem       (bus)
   );

   typedef struct {
      logic  stall;
      logic  n_me;
      logic  n_oe;
      logic  n_we;
      logic  oe;
      logic  done;
      logic  bus_err;
      word_t addr;
      word_t wr_data;
      word_t data_in;
   } cyc_exp_t;

   typedef struct {
      int    cyc;
      word_t addr;
      word_t wr_data;
      word_t data_in;
      logic  bus_err;
   } done_exp_t;

   cyc_exp_t  cyc_exp [int];
   done_exp_t sb_q [$];
   word_t     mdl_addr = 16'h0000;
   word_t     mdl_wr   = 16'h0000;
   word_t     mdl_din  = 16'h0000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic set_exp(input int c, input logic st, input logic me, input logic oen, input logic wen,
                          input logic oe, input logic dn, input logic be,
                          input word_t a, input word_t w, input word_t di);
      cyc_exp_t e;
      e.stall = st;  e.n_me = me;  e.n_oe = oen; e.n_we = wen; e.oe = oe;
      e.done = dn;   e.bus_err = be; e.addr = a; e.wr_data = w; e.data_in = di;
      cyc_exp[c] = e;
   endtask

   // One request issued in the current cycle; w = number of low nWait samples (w > TO means stuck).
   task automatic apply_stimulus(input logic wr, input word_t a, input word_t d, input int w, input logic noise);
      int        n;
      int        wait_cyc;
      int        done_c;
      logic      tmo;
      word_t     prev_w;
      word_t     prev_d;
      done_exp_t t;
      n        = cyc;
      tmo      = (w > TO);
      wait_cyc = tmo ? TO : w;
      done_c   = n + 2 + WM + wait_cyc;
      prev_w   = mdl_wr;
      prev_d   = mdl_din;
      set_exp(n, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mdl_addr, prev_w, prev_d);
      mdl_addr = a;
      if (wr) mdl_wr = d;
      if (!wr && !tmo) mdl_din = d;
      set_exp(n + 1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a, prev_w, prev_d);
      for (int c = n + 2; c < done_c; c++)
         set_exp(c, 1'b1, 1'b0, wr, !wr, wr, 1'b0, 1'b0, a, mdl_wr, prev_d);
      set_exp(done_c, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, tmo, a, mdl_wr, mdl_din);
      t.cyc = done_c; t.addr = a; t.wr_data = mdl_wr; t.data_in = mdl_din; t.bus_err = tmo;
      sb_q.push_back(t);
      for (int c = n; c <= done_c; c++) begin
         read_req  = 1'b0;
         write_req = 1'b0;
         sys_bus   = 16'($urandom);
         if (c == n) begin
            sys_bus   = a;
            read_req  = !wr;
            write_req = wr;
         end else begin
            if (c == n + 1) sys_bus = d;
            if (noise && ($urandom_range(0, 3) == 0)) begin
               read_req  = 1'($urandom);
               write_req = 1'($urandom);
            end
         end
         bus.n_wait   = !((c >= n + 1 + WM) && (c < n + 1 + WM + w));
         bus.ext_data = ((c == done_c - 1) && !wr && !tmo) ? d : 16'($urandom);
         @(posedge clk); #1;
      end
      read_req   = 1'b0;
      write_req  = 1'b0;
      bus.n_wait = 1'b1;
   endtask

   task automatic both_req();
      int m;
      m = cyc;
      set_exp(m,     1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mdl_addr, mdl_wr, mdl_din);
      set_exp(m + 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, mdl_addr, mdl_wr, mdl_din);
      set_exp(m + 2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, mdl_addr, mdl_wr, mdl_din);
      sys_bus   = 16'hDEAD;
      read_req  = 1'b1;
      write_req = 1'b1;
      @(posedge clk); #1;
      read_req  = 1'b0;
      write_req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
   endtask

   task automatic reset_mid_access();
      sys_bus    = 16'h3C3C;
      read_req   = 1'b1;
      bus.n_wait = 1'b0;
      @(posedge clk); #1;
      read_req = 1'b0;
      @(posedge clk); #1;
      check_output("pre_reset_n_me", 32'(bus.n_me), 32'(1'b0));
      rst_n = 1'b0;
      #1;
      check_output("rst_n_me", 32'(bus.n_me), 32'(1'b1));
      check_output("rst_n_oe", 32'(bus.n_oe), 32'(1'b1));
      check_output("rst_n_we", 32'(bus.n_we), 32'(1'b1));
      check_output("rst_stall", 32'(stall), 32'(1'b0));
      check_output("rst_addr", 32'(bus.addr), 32'h0);
      check_output("rst_data_in", 32'(data_in), 32'h0);
      mdl_addr = 16'h0000;
      mdl_wr   = 16'h0000;
      mdl_din  = 16'h0000;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n      = 1'b1;
      bus.n_wait = 1'b1;
      @(posedge clk); #1;
   endtask

   // Monitor: per-cycle expectations plus a done-event scoreboard.
   cyc_exp_t  me;
   done_exp_t mt;
   always @(negedge clk) begin
      if (cyc_exp.exists(cyc)) begin
         me = cyc_exp[cyc];
         cyc_exp.delete(cyc);
         check_output("stall",      32'(stall),          32'(me.stall));
         check_output("n_me",       32'(bus.n_me),       32'(me.n_me));
         check_output("n_oe",       32'(bus.n_oe),       32'(me.n_oe));
         check_output("n_we",       32'(bus.n_we),       32'(me.n_we));
         check_output("wr_data_oe", 32'(bus.wr_data_oe), 32'(me.oe));
         check_output("done",       32'(done),           32'(me.done));
         check_output("bus_err",    32'(bus_err),        32'(me.bus_err));
         check_output("addr",       32'(bus.addr),       32'(me.addr));
         check_output("wr_data",    32'(bus.wr_data),    32'(me.wr_data));
         check_output("data_in",    32'(data_in),        32'(me.data_in));
      end
      if (done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_output("done_spurious", 32'(done), 32'(1'b0));
         end else begin
            mt = sb_q.pop_front();
            check_output("sb_done_cycle", 32'(cyc),         32'(mt.cyc));
            check_output("sb_addr",       32'(bus.addr),    32'(mt.addr));
            check_output("sb_wr_data",    32'(bus.wr_data), 32'(mt.wr_data));
            check_output("sb_data_in",    32'(data_in),     32'(mt.data_in));
            check_output("sb_bus_err",    32'(bus_err),     32'(mt.bus_err));
         end
      end
   end

   initial begin
      rst_n        = 1'b1;
      read_req     = 1'b0;
      write_req    = 1'b0;
      sys_bus      = 16'h0000;
      bus.n_wait   = 1'b1;
      bus.ext_data = 16'h0000;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_n_me",       32'(bus.n_me),       32'(1'b1));
      check_output("reset_n_oe",       32'(bus.n_oe),       32'(1'b1));
      check_output("reset_n_we",       32'(bus.n_we),       32'(1'b1));
      check_output("reset_wr_data_oe", 32'(bus.wr_data_oe), 32'(1'b0));
      check_output("reset_stall",      32'(stall),          32'(1'b0));
      check_output("reset_done",       32'(done),           32'(1'b0));
      check_output("reset_bus_err",    32'(bus_err),        32'(1'b0));
      check_output("reset_addr",       32'(bus.addr),       32'h0);
      check_output("reset_wr_data",    32'(bus.wr_data),    32'h0);
      check_output("reset_data_in",    32'(data_in),        32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      apply_stimulus(1'b0, 16'h1234, 16'hBEEF, 0,    1'b0);
      apply_stimulus(1'b1, 16'h0040, 16'hA5A5, 0,    1'b0);
      apply_stimulus(1'b0, 16'h2222, 16'h5A5A, 4,    1'b0);
      apply_stimulus(1'b0, 16'h3333, 16'h0F0F, 1000, 1'b0);
      apply_stimulus(1'b0, 16'h4444, 16'h1111, TO,   1'b0);
      apply_stimulus(1'b1, 16'h5555, 16'h6666, TO+1, 1'b0);
      both_req();

      for (int i = 0; i < 40; i++) begin
         logic wr;
         int   w;
         wr = 1'($urandom);
         if ($urandom_range(0, 5) == 0) w = int'($urandom_range(10, 20));
         else                           w = int'($urandom_range(0, 3));
         apply_stimulus(wr, 16'($urandom), 16'($urandom), w, 1'b1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      reset_mid_access();
      apply_stimulus(1'b0, 16'h7777, 16'h8888, 0, 1'b0);

      repeat (2) begin
         @(posedge clk); #1;
      end
      check_output("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
